timer_bus_responder: RTL and testbench

TIMER_BUS_RESPONDER -- requirements
Module: timer_bus_responder

---
 rtl/timer_bus_responder.sv | 160 ++++++++++++++++
 tb/tb_timer_bus_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bus_responder.sv
// timer_bus_responder
//   Memory-mapped 32-bit timer on the data bus, with a 16-byte register window:
//     +0x0 CTRL    bit0 EN, bit1 RELOAD, bit2 IRQEN
//     +0x4 COUNT   free-running counter while enabled
//     +0x8 COMPARE match value
//     +0xC STATUS  bit0 MATCH (write-1-to-clear)
//   Ports:
//     iCLK, iRST         clock, asynchronous active-high reset
//     iReadEnable        read strobe; reads are combinational
//     iWriteEnable       write strobe; writes land on posedge iCLK
//     iByteEnable[3:0]   write byte lanes
//     iAddress[31:0]     byte address (bits [1:0] ignored)
//     iWriteData[31:0]   write data
//     oReadData[31:0]    addressed register, high-Z when not driving
//     oSelected          address falls inside the register window
//     oPendingInterrupt  MATCH & IRQEN on bit IRQ_BIT, other bits 0
module timer_bus_responder #(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0000,
  parameter int unsigned IRQ_BIT   = 7
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [3:0]  iByteEnable,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  output logic        oSelected,
  output logic [7:0]  oPendingInterrupt
);

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t      state;
  logic        ctrlEn;
  logic        ctrlReload;
  logic        ctrlIrqEn;
  logic        match;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] readMux;

  logic        wrCtrl;
  logic        wrCount;
  logic        wrCompare;
  logic        wrStatus;
  logic        hwMatch;
  logic        unusedAddrBits;

  // Replace the enabled byte lanes of oldVal with those of newVal.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = oldVal;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        r[8*i +: 8] = newVal[8*i +: 8];
      end
    end
    return r;
  endfunction

  assign unusedAddrBits = ^iAddress[1:0];

  assign oSelected = (iAddress[31:4] == BASE_ADDR[31:4]);
  assign wrCtrl    = oSelected && iWriteEnable && (iAddress[3:2] == 2'd0);
  assign wrCount   = oSelected && iWriteEnable && (iAddress[3:2] == 2'd1);
  assign wrCompare = oSelected && iWriteEnable && (iAddress[3:2] == 2'd2);
  assign wrStatus  = oSelected && iWriteEnable && (iAddress[3:2] == 2'd3);

  // Compare happens on the pre-increment count.
  assign hwMatch = (state == RUNNING) && (count == compare);

  // Register read multiplexer.
  always_comb begin
    readMux = 32'd0;
    case (iAddress[3:2])
      2'd0:    readMux = {29'd0, ctrlIrqEn, ctrlReload, ctrlEn};
      2'd1:    readMux = count;
      2'd2:    readMux = compare;
      2'd3:    readMux = {31'd0, match};
      default: readMux = 32'd0;
    endcase
  end

  assign oReadData = (oSelected && iReadEnable) ? readMux : 32'hzzzz_zzzz;

  // Interrupt line toward COP0.
  always_comb begin
    oPendingInterrupt          = 8'h00;
    oPendingInterrupt[IRQ_BIT] = match & ctrlIrqEn;
  end

  // Timer FSM and registers. Hardware updates are assigned first; bus
  // writes later in the block override them, except the W1C of MATCH,
  // which is suppressed when a hardware match lands on the same edge.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= STOPPED;
      ctrlEn     <= 1'b0;
      ctrlReload <= 1'b0;
      ctrlIrqEn  <= 1'b0;
      match      <= 1'b0;
      count      <= 32'd0;
      compare    <= 32'd0;
    end else begin
      case (state)
        RUNNING: begin
          count <= count + 32'd1;
          if (hwMatch) begin
            match <= 1'b1;
            if (ctrlReload) begin
              count <= 32'd0;
            end else begin
              // One-shot: the increment leaves COUNT at COMPARE+1.
              ctrlEn <= 1'b0;
              state  <= EXPIRED;
            end
          end
        end
        default: begin
        end
      endcase

      if (wrCount) begin
        count <= mergeBytes(count, iWriteData, iByteEnable);
      end

      if (wrCompare) begin
        compare <= mergeBytes(compare, iWriteData, iByteEnable);
      end

      if (wrStatus && iByteEnable[0] && iWriteData[0] && !hwMatch) begin
        match <= 1'b0;
        // EN is always 0 in EXPIRED, so clearing MATCH ends the episode.
        if (state == EXPIRED) begin
          state <= STOPPED;
        end
      end

      if (wrCtrl && iByteEnable[0]) begin
        ctrlEn     <= iWriteData[0];
        ctrlReload <= iWriteData[1];
        ctrlIrqEn  <= iWriteData[2];
        if (iWriteData[0]) begin
          state <= RUNNING;
        end else if (state == RUNNING) begin
          state <= STOPPED;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_bus_responder.sv
// Self-checking bench for timer_bus_responder: a per-cycle vector table
// followed by hand-written sequences for one-shot, bus/hardware races,
// counter wrap and asynchronous reset.
module tb_timer_bus_responder;

  localparam logic [31:0] B     = 32'hFF20_0000;
  localparam logic [31:0] ACTRL = B + 32'h0;
  localparam logic [31:0] ACNT  = B + 32'h4;
  localparam logic [31:0] ACMP  = B + 32'h8;
  localparam logic [31:0] ASTAT = B + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  wire  [31:0] rdata;
  wire         sel;
  wire  [7:0]  irq;

  int checks = 0;
  int errors = 0;

  timer_bus_responder dut (
    .iCLK              (clk),
    .iRST              (rst),
    .iReadEnable       (rd),
    .iWriteEnable      (wr),
    .iByteEnable       (be),
    .iAddress          (addr),
    .iWriteData        (wdata),
    .oReadData         (rdata),
    .oSelected         (sel),
    .oPendingInterrupt (irq)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
    logic        expSel;
    logic [7:0]  expIrq;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t V(input logic r, input logic w, input logic [3:0] b,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] er, input logic es,
                             input logic [7:0] ei);
    vec_t v;
    v.rd = r; v.wr = w; v.be = b; v.addr = a; v.wdata = d;
    v.expRd = er; v.expSel = es; v.expIrq = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleCycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    addr = a; wdata = d; be = b; wr = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0; be = 4'h0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    #1;
    d = rdata;
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    busRead(a, d);
    check(name, d, exp);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rd = 1'b0; wr = 1'b0; be = 4'h0; addr = B; wdata = 32'd0;
    rst = 1'b1;

    // Reset state with reads while iRST is high.
    #3;
    check("reset_irq", {24'd0, irq}, 32'h0);
    rd = 1'b1; addr = ACNT; #1;
    check("reset_read_count", rdata, 32'h0);
    rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Per-cycle vectors: compare byte lanes, auto-reload, W1C race,
    // COUNT write race, decode, disable.
    vecs[0]  = V(1'b1, 1'b0, 4'h0, ACTRL, 32'h0,          32'h0,        1'b1, 8'h00);
    vecs[1]  = V(1'b1, 1'b0, 4'h0, ACNT,  32'h0,          32'h0,        1'b1, 8'h00);
    vecs[2]  = V(1'b0, 1'b1, 4'hF, ACMP,  32'hAABB_CCDD,  32'h0,        1'b1, 8'h00);
    vecs[3]  = V(1'b0, 1'b1, 4'h5, ACMP,  32'h1122_3344,  32'h0,        1'b1, 8'h00);
    vecs[4]  = V(1'b1, 1'b0, 4'h0, ACMP,  32'h0,          32'hAA22_CC44, 1'b1, 8'h00);
    vecs[5]  = V(1'b0, 1'b1, 4'hF, ACMP,  32'h3,          32'h0,        1'b1, 8'h00);
    vecs[6]  = V(1'b0, 1'b1, 4'hF, ACTRL, 32'h7,          32'h0,        1'b1, 8'h00);
    vecs[7]  = V(1'b1, 1'b0, 4'h0, ACNT,  32'h0,          32'h0,        1'b1, 8'h00);
    vecs[8]  = V(1'b1, 1'b0, 4'h0, ACNT,  32'h0,          32'h1,        1'b1, 8'h00);
    vecs[9]  = V(1'b1, 1'b0, 4'h0, ACNT,  32'h0,          32'h2,        1'b1, 8'h00);
    vecs[10] = V(1'b1, 1'b0, 4'h0, ACNT,  32'h0,          32'h3,        1'b1, 8'h00);
    vecs[11] = V(1'b1, 1'b0, 4'h0, ACNT,  32'h0,          32'h0,        1'b1, 8'h80);
    vecs[12] = V(1'b1, 1'b0, 4'h0, ASTAT, 32'h0,          32'h1,        1'b1, 8'h80);
    vecs[13] = V(1'b0, 1'b1, 4'h1, ASTAT, 32'h1,          32'h0,        1'b1, 8'h80);
    vecs[14] = V(1'b1, 1'b1, 4'h1, ASTAT, 32'h1,          32'h0,        1'b1, 8'h00);
    vecs[15] = V(1'b1, 1'b0, 4'h0, ASTAT, 32'h0,          32'h1,        1'b1, 8'h80);
    vecs[16] = V(1'b1, 1'b0, 4'h0, ACNT,  32'h0,          32'h1,        1'b1, 8'h80);
    vecs[17] = V(1'b0, 1'b1, 4'hF, ACNT,  32'h10,         32'h0,        1'b1, 8'h80);
    vecs[18] = V(1'b1, 1'b0, 4'h0, ACNT,  32'h0,          32'h10,       1'b1, 8'h80);
    vecs[19] = V(1'b1, 1'b0, 4'h0, ACNT,  32'h0,          32'h11,       1'b1, 8'h80);
    vecs[20] = V(1'b1, 1'b0, 4'h0, B + 32'h10, 32'h0,     32'h0,        1'b0, 8'h80);
    vecs[21] = V(1'b0, 1'b1, 4'hF, B + 32'h14, 32'hDEAD,  32'h0,        1'b0, 8'h80);
    vecs[22] = V(1'b1, 1'b0, 4'h0, ACNT,  32'h0,          32'h14,       1'b1, 8'h80);
    vecs[23] = V(1'b0, 1'b1, 4'h1, ACTRL, 32'h0,          32'h0,        1'b1, 8'h80);
    vecs[24] = V(1'b1, 1'b0, 4'h0, ACTRL, 32'h0,          32'h0,        1'b1, 8'h00);
    vecs[25] = V(1'b1, 1'b0, 4'h0, ACNT,  32'h0,          32'h16,       1'b1, 8'h00);
    vecs[26] = V(1'b1, 1'b0, 4'h0, ACNT,  32'h0,          32'h16,       1'b1, 8'h00);
    vecs[27] = V(1'b1, 1'b0, 4'h0, ASTAT, 32'h0,          32'h1,        1'b1, 8'h00);

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      rd = vecs[i].rd; wr = vecs[i].wr; be = vecs[i].be;
      addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_sel", i), {31'd0, sel}, {31'd0, vecs[i].expSel});
      check($sformatf("vec%0d_irq", i), {24'd0, irq}, {24'd0, vecs[i].expIrq});
      if (vecs[i].rd && vecs[i].expSel) begin
        check($sformatf("vec%0d_rdata", i), rdata, vecs[i].expRd);
      end else if (vecs[i].rd) begin
        checks++;
        if (!((rdata === 32'hzzzz_zzzz) || (rdata === 32'h0))) begin
          errors++;
          $display("FAIL vec%0d_rdata_hiz: got %h expected zzzzzzzz", i, rdata);
        end
      end
    end
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; be = 4'h0;

    // One-shot: stops at COMPARE+1, hardware clears EN, W1C ends it.
    doReset();
    busWrite(ACMP, 32'h2, 4'hF);
    busWrite(ACTRL, 32'h5, 4'hF);
    repeat (5) idleCycle();
    readCheck("oneshot_count", ACNT, 32'h3);
    readCheck("oneshot_ctrl", ACTRL, 32'h4);
    readCheck("oneshot_status", ASTAT, 32'h1);
    check("oneshot_irq", {24'd0, irq}, 32'h80);
    busWrite(ASTAT, 32'h1, 4'h1);
    readCheck("oneshot_status_clr", ASTAT, 32'h0);
    check("oneshot_irq_clr", {24'd0, irq}, 32'h0);
    idleCycle();
    idleCycle();
    readCheck("oneshot_count_held", ACNT, 32'h3);

    // Bus write of EN=1 on the one-shot match edge keeps the timer running.
    doReset();
    busWrite(ACMP, 32'h2, 4'hF);
    busWrite(ACTRL, 32'h5, 4'hF);
    idleCycle();
    idleCycle();
    busWrite(ACTRL, 32'h5, 4'hF);
    readCheck("race_en_ctrl", ACTRL, 32'h5);
    readCheck("race_en_count", ACNT, 32'h4);
    readCheck("race_en_status", ASTAT, 32'h1);

    // Asynchronous reset between edges while RUNNING with MATCH=1.
    @(negedge clk);
    #2;
    check("arst_pre_irq", {24'd0, irq}, 32'h80);
    rst = 1'b1;
    #1;
    check("arst_irq", {24'd0, irq}, 32'h0);
    rd = 1'b1; addr = ACTRL; #1;
    check("arst_ctrl", rdata, 32'h0);
    addr = ACNT; #1;
    check("arst_count", rdata, 32'h0);
    addr = ACMP; #1;
    check("arst_compare", rdata, 32'h0);
    addr = ASTAT; #1;
    check("arst_status", rdata, 32'h0);
    rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idleCycle();
    idleCycle();
    readCheck("arst_count_after", ACNT, 32'h0);

    // Counter wrap without a match.
    doReset();
    busWrite(ACNT, 32'hFFFF_FFFF, 4'hF);
    busWrite(ACMP, 32'h5, 4'hF);
    busWrite(ACTRL, 32'h1, 4'hF);
    readCheck("wrap_count_max", ACNT, 32'hFFFF_FFFF);
    readCheck("wrap_count_zero", ACNT, 32'h0);
    readCheck("wrap_status", ASTAT, 32'h0);
    check("wrap_irq", {24'd0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
